mem_access: RTL and testbench

//  Memory-access stage between EXE and WB. Takes EXE's address, store data and mem_control.

---
 rtl/mem_access_if.sv | 22 ++
 rtl/mem_access.sv | 186 ++++++++++++++++++
 tb/tb_mem_access.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_if.sv
// Data SRAM port in req/addr_ok/data_ok style. The master drives the request;
// the slave (memory) answers with accept and data handshakes.
interface mem_access_if;
  logic        data_sram_req;
  logic        data_sram_wr;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;

  modport master (
    output data_sram_req, data_sram_wr, data_sram_wstrb, data_sram_addr, data_sram_wdata,
    input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
  );

  modport slave (
    input  data_sram_req, data_sram_wr, data_sram_wstrb, data_sram_addr, data_sram_wdata,
    output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
  );
endinterface

// File: rtl/mem_access.sv
// Memory-access pipeline stage: issues load/store transactions on the data SRAM,
// detects misaligned accesses and aligns load data before write-back.
module mem_access #(
  parameter int PASS_W = 100
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MEM_valid,
  input  logic              MEM_flush,
  input  logic              WB_allow_in,
  input  logic [4:0]        mem_control,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       exe_result,
  input  logic [31:0]       store_data,
  input  logic              ls_bytes_L,
  input  logic              ls_bytes_R,
  input  logic [3:0]        rf_wbytes_in,
  input  logic [PASS_W-1:0] pass_in,
  mem_access_if.master      dsram,
  output logic              MEM_over,
  output logic [31:0]       MEM_result,
  output logic [3:0]        MEM_wbytes,
  output logic              MEM_adel,
  output logic              MEM_ades,
  output logic [31:0]       MEM_badvaddr,
  output logic              MEM_load_busy,
  output logic [PASS_W-1:0] pass_out
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    DRAIN = 3'd4
  } state_e;

  state_e      state_q;
  logic        req_q;
  logic        wr_q;
  logic [3:0]  wstrb_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;

  logic        is_load_s, is_store_s, is_mem_s, sext_s, misalign_s, acc_s;
  logic [1:0]  size_s, n_s;
  logic [3:0]  strb_s;
  logic [31:0] wdata_s, shr_s, load_s;

  assign is_load_s  = mem_control[4];
  assign is_store_s = mem_control[3];
  assign size_s     = mem_control[2:1];
  assign sext_s     = mem_control[0];
  assign is_mem_s   = is_load_s | is_store_s;
  assign n_s        = mem_addr[1:0];
  assign acc_s      = MEM_valid & is_mem_s & ~misalign_s & ~MEM_flush;
  assign shr_s      = rdata_q >> {n_s, 3'b000};

  // Alignment check and store lane/strobe generation
  always_comb begin
    misalign_s = 1'b0;
    strb_s     = 4'b0000;
    wdata_s    = store_data;
    case (size_s)
      2'b00: begin
        strb_s  = 4'b0001 << n_s;
        wdata_s = {4{store_data[7:0]}};
      end
      2'b01: begin
        misalign_s = is_mem_s & n_s[0];
        strb_s     = n_s[1] ? 4'b1100 : 4'b0011;
        wdata_s    = {2{store_data[15:0]}};
      end
      2'b10: begin
        misalign_s = is_mem_s & ~(ls_bytes_L | ls_bytes_R) & (n_s != 2'b00);
        strb_s     = 4'b1111;
      end
      default: begin
        strb_s = 4'b1111;
      end
    endcase
  end

  // Load alignment and extension from the latched word
  always_comb begin
    load_s = rdata_q;
    case (size_s)
      2'b00: load_s = {{24{sext_s & shr_s[7]}}, shr_s[7:0]};
      2'b01: load_s = {{16{sext_s & shr_s[15]}}, shr_s[15:0]};
      default: begin
        if (ls_bytes_L) begin
          load_s = rdata_q << {2'd3 - n_s, 3'b000};
        end else if (ls_bytes_R) begin
          load_s = shr_s;
        end else begin
          load_s = rdata_q;
        end
      end
    endcase
  end

  // Transaction FSM; request fields are captured once and held until accepted
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      wr_q    <= 1'b0;
      wstrb_q <= 4'b0000;
      addr_q  <= 32'h0000_0000;
      wdata_q <= 32'h0000_0000;
      rdata_q <= 32'h0000_0000;
    end else begin
      case (state_q)
        IDLE: begin
          if (acc_s) begin
            state_q <= REQ;
            req_q   <= 1'b1;
            wr_q    <= is_store_s;
            wstrb_q <= is_store_s ? strb_s : 4'b0000;
            addr_q  <= {mem_addr[31:2], 2'b00};
            wdata_q <= wdata_s;
          end
        end
        REQ: begin
          if (dsram.data_sram_addr_ok) begin
            req_q   <= 1'b0;
            state_q <= MEM_flush ? DRAIN : WAIT;
          end else if (MEM_flush) begin
            req_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        WAIT: begin
          if (MEM_flush) begin
            state_q <= dsram.data_sram_data_ok ? IDLE : DRAIN;
          end else if (dsram.data_sram_data_ok) begin
            state_q <= DONE;
            rdata_q <= dsram.data_sram_rdata;
          end
        end
        DRAIN: begin
          if (dsram.data_sram_data_ok) state_q <= IDLE;
        end
        DONE: begin
          if (WB_allow_in | MEM_flush) state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign dsram.data_sram_req   = req_q;
  assign dsram.data_sram_wr    = wr_q;
  assign dsram.data_sram_wstrb = wstrb_q;
  assign dsram.data_sram_addr  = addr_q;
  assign dsram.data_sram_wdata = wdata_q;

  // Stage outputs, all gated by MEM_valid
  always_comb begin
    MEM_over      = 1'b0;
    MEM_result    = 32'h0000_0000;
    MEM_wbytes    = 4'b0000;
    MEM_adel      = 1'b0;
    MEM_ades      = 1'b0;
    MEM_badvaddr  = 32'h0000_0000;
    MEM_load_busy = 1'b0;
    pass_out      = '0;
    if (MEM_valid) begin
      MEM_adel   = is_load_s & misalign_s;
      MEM_ades   = is_store_s & misalign_s;
      MEM_over   = (~is_mem_s | misalign_s) ? 1'b1 : (state_q == DONE);
      MEM_result = (is_load_s & ~misalign_s) ? load_s : exe_result;
      MEM_wbytes = misalign_s ? 4'b0000 : rf_wbytes_in;
      MEM_badvaddr  = misalign_s ? mem_addr : 32'h0000_0000;
      MEM_load_busy = is_load_s & ~MEM_over;
      pass_out      = pass_in;
    end else begin
      MEM_over = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: hand-computed vectors checked with immediate assertions.
module tb_mem_access;
  localparam int PASS_W = 100;

  logic              clk = 1'b0;
  logic              reset;
  logic              MEM_valid, MEM_flush, WB_allow_in;
  logic [4:0]        mem_control;
  logic [31:0]       mem_addr, exe_result, store_data;
  logic              ls_bytes_L, ls_bytes_R;
  logic [3:0]        rf_wbytes_in;
  logic [PASS_W-1:0] pass_in, pass_out;
  logic              MEM_over, MEM_adel, MEM_ades, MEM_load_busy;
  logic [31:0]       MEM_result, MEM_badvaddr;
  logic [3:0]        MEM_wbytes;

  int n_checks = 0;
  int n_fail   = 0;

  mem_access_if dsram ();

  mem_access #(.PASS_W(PASS_W)) dut (
    .clk(clk), .reset(reset), .MEM_valid(MEM_valid), .MEM_flush(MEM_flush),
    .WB_allow_in(WB_allow_in), .mem_control(mem_control), .mem_addr(mem_addr),
    .exe_result(exe_result), .store_data(store_data), .ls_bytes_L(ls_bytes_L),
    .ls_bytes_R(ls_bytes_R), .rf_wbytes_in(rf_wbytes_in), .pass_in(pass_in),
    .dsram(dsram.master), .MEM_over(MEM_over), .MEM_result(MEM_result),
    .MEM_wbytes(MEM_wbytes), .MEM_adel(MEM_adel), .MEM_ades(MEM_ades),
    .MEM_badvaddr(MEM_badvaddr), .MEM_load_busy(MEM_load_busy), .pass_out(pass_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [PASS_W-1:0] obs, input logic [PASS_W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [4:0] ctrl, input logic [31:0] addr, input logic [31:0] sd);
    MEM_valid   = 1'b1;
    mem_control = ctrl;
    mem_addr    = addr;
    store_data  = sd;
    #1;
  endtask

  // Full handshake with addr_ok in the request cycle and data_ok the cycle after
  task automatic handshake(input logic [31:0] rd);
    step();
    chk("req_up", dsram.data_sram_req, 1);
    dsram.data_sram_addr_ok = 1'b1;
    step();
    dsram.data_sram_addr_ok = 1'b0;
    dsram.data_sram_data_ok = 1'b1;
    dsram.data_sram_rdata   = rd;
    step();
    dsram.data_sram_data_ok = 1'b0;
  endtask

  task automatic retire();
    MEM_valid = 1'b0;
    ls_bytes_L = 1'b0;
    ls_bytes_R = 1'b0;
    step();
  endtask

  initial begin
    reset = 1'b1; MEM_valid = 1'b0; MEM_flush = 1'b0; WB_allow_in = 1'b1;
    mem_control = 5'b00000; mem_addr = 32'h0; exe_result = 32'h0; store_data = 32'h0;
    ls_bytes_L = 1'b0; ls_bytes_R = 1'b0; rf_wbytes_in = 4'hF;
    pass_in = {4'hA, 32'h0123_4567, 32'h89AB_CDEF, 32'h5A5A_A5A5};
    dsram.data_sram_addr_ok = 1'b0; dsram.data_sram_data_ok = 1'b0; dsram.data_sram_rdata = 32'h0;
    step(); step();
    reset = 1'b0;
    #1;
    chk("rst_req", dsram.data_sram_req, 0);
    chk("rst_over", MEM_over, 0);
    chk("rst_result", MEM_result, 0);

    // LW 0x100: over only in cycle 3
    start(5'b10100, 32'h0000_0100, 32'h0);
    chk("lw_c0_over", MEM_over, 0);
    chk("lw_c0_busy", MEM_load_busy, 1);
    chk("lw_c0_req", dsram.data_sram_req, 0);
    step();
    chk("lw_c1_req", dsram.data_sram_req, 1);
    chk("lw_c1_addr", dsram.data_sram_addr, 32'h0000_0100);
    chk("lw_c1_wr", dsram.data_sram_wr, 0);
    chk("lw_c1_wstrb", dsram.data_sram_wstrb, 0);
    dsram.data_sram_addr_ok = 1'b1;
    step();
    dsram.data_sram_addr_ok = 1'b0;
    chk("lw_c2_req", dsram.data_sram_req, 0);
    chk("lw_c2_over", MEM_over, 0);
    dsram.data_sram_data_ok = 1'b1;
    dsram.data_sram_rdata   = 32'hDEAD_BEEF;
    step();
    dsram.data_sram_data_ok = 1'b0;
    chk("lw_c3_over", MEM_over, 1);
    chk("lw_c3_result", MEM_result, 32'hDEAD_BEEF);
    chk("lw_c3_busy", MEM_load_busy, 0);
    retire();
    chk("idle_over", MEM_over, 0);

    // LB / LBU / LH at high byte lanes
    start(5'b10001, 32'h0000_0103, 32'h0);
    handshake(32'h8011_2233);
    chk("lb_result", MEM_result, 32'hFFFF_FF80);
    retire();
    start(5'b10000, 32'h0000_0103, 32'h0);
    handshake(32'h8011_2233);
    chk("lbu_result", MEM_result, 32'h0000_0080);
    retire();
    start(5'b10011, 32'h0000_0102, 32'h0);
    handshake(32'h8011_2233);
    chk("lh_result", MEM_result, 32'hFFFF_8011);
    retire();

    // LWL / LWR at byte offset 1
    ls_bytes_L = 1'b1;
    start(5'b10100, 32'h0000_0101, 32'h0);
    chk("lwl_no_adel", MEM_adel, 0);
    handshake(32'h1122_3344);
    chk("lwl_result", MEM_result, 32'h3344_0000);
    retire();
    ls_bytes_R = 1'b1;
    start(5'b10100, 32'h0000_0101, 32'h0);
    handshake(32'h1122_3344);
    chk("lwr_result", MEM_result, 32'h0011_2233);
    retire();

    // SH 0x102 with addr_ok held low for 4 cycles, then WB stalls in DONE
    start(5'b01010, 32'h0000_0102, 32'h0000_ABCD);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("sh_req", dsram.data_sram_req, 1);
      chk("sh_wr", dsram.data_sram_wr, 1);
      chk("sh_wstrb", dsram.data_sram_wstrb, 4'b1100);
      chk("sh_wdata", dsram.data_sram_wdata, 32'hABCD_ABCD);
      chk("sh_addr", dsram.data_sram_addr, 32'h0000_0100);
    end
    dsram.data_sram_addr_ok = 1'b1;
    step();
    dsram.data_sram_addr_ok = 1'b0;
    dsram.data_sram_data_ok = 1'b1;
    WB_allow_in = 1'b0;
    step();
    dsram.data_sram_data_ok = 1'b0;
    chk("sh_over", MEM_over, 1);
    step(); step();
    chk("sh_over_held", MEM_over, 1);
    WB_allow_in = 1'b1;
    retire();

    // SB 0x101
    start(5'b01000, 32'h0000_0101, 32'h1234_5678);
    step();
    chk("sb_wstrb", dsram.data_sram_wstrb, 4'b0010);
    chk("sb_wdata", dsram.data_sram_wdata, 32'h7878_7878);
    dsram.data_sram_addr_ok = 1'b1;
    step();
    dsram.data_sram_addr_ok = 1'b0;
    dsram.data_sram_data_ok = 1'b1;
    step();
    dsram.data_sram_data_ok = 1'b0;
    retire();

    // Misaligned LW / SW
    start(5'b10100, 32'h0000_0101, 32'h0);
    chk("adel_flag", MEM_adel, 1);
    chk("adel_over", MEM_over, 1);
    chk("adel_bad", MEM_badvaddr, 32'h0000_0101);
    chk("adel_wbytes", MEM_wbytes, 0);
    step();
    chk("adel_noreq", dsram.data_sram_req, 0);
    retire();
    start(5'b01100, 32'h0000_0102, 32'h0);
    chk("ades_flag", MEM_ades, 1);
    chk("ades_adel", MEM_adel, 0);
    step();
    chk("ades_noreq", dsram.data_sram_req, 0);
    retire();

    // Non-memory instruction passes straight through
    exe_result = 32'h1234_5678;
    start(5'b00000, 32'h0000_0101, 32'h0);
    chk("alu_over", MEM_over, 1);
    chk("alu_result", MEM_result, 32'h1234_5678);
    chk("alu_wbytes", MEM_wbytes, 4'hF);
    chk("alu_pass", pass_out, {4'hA, 32'h0123_4567, 32'h89AB_CDEF, 32'h5A5A_A5A5});
    chk("alu_badv", MEM_badvaddr, 0);
    retire();

    // Flush in WAIT; next load waits for the stale data_ok
    start(5'b10100, 32'h0000_0200, 32'h0);
    step();
    dsram.data_sram_addr_ok = 1'b1;
    step();
    dsram.data_sram_addr_ok = 1'b0;
    MEM_flush = 1'b1;
    #1;
    step();
    MEM_flush = 1'b0;
    start(5'b10100, 32'h0000_0300, 32'h0);
    chk("drain_over", MEM_over, 0);
    chk("drain_req", dsram.data_sram_req, 0);
    step();
    chk("drain_req2", dsram.data_sram_req, 0);
    dsram.data_sram_data_ok = 1'b1;
    dsram.data_sram_rdata   = 32'h5555_5555;
    #1;
    chk("drain_over2", MEM_over, 0);
    step();
    dsram.data_sram_data_ok = 1'b0;
    chk("drain_req3", dsram.data_sram_req, 0);
    handshake(32'hCAFE_F00D);
    chk("post_addr", dsram.data_sram_addr, 32'h0000_0300);
    chk("post_result", MEM_result, 32'hCAFE_F00D);
    chk("post_over", MEM_over, 1);
    retire();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
